multi_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the single-bit edge detector.
- Each channel synchronises an asynchronous input, deglitches it with a stability filter, and detects rising, falling or both edges according to a per-channel mode.
- Per channel, it outputs a one-cycle event pulse, a sticky event flag and a saturating event counter.
- Sits between external GPIO/status lines and the interrupt/status register block.

---
 rtl/multi_edge_detector.sv | 150 +++++++++++++++
 tb/tb_multi_edge_detector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector. Each channel runs its asynchronous input through a
//   synchroniser chain and then through a stability filter. It then detects rising,
//   falling or both edges of the filtered level, depending on the channel's mode.
//   Each qualified edge produces three results on the same clock edge: a one-cycle pulse,
//   a sticky flag, and an increment of a saturating event counter.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset (released synchronously upstream)
//   i_data_in  [N_CH]         asynchronous channel inputs
//   i_mode     [2*N_CH]       per channel {fall_en, rise_en}: 00 off, 01 rise, 10 fall, 11 both
//   i_clr      [N_CH]         synchronous clear of flag and counter (an event wins over clear)
//   o_level    [N_CH]         filtered, synchronised level
//   o_pulse    [N_CH]         one-cycle pulse per qualified edge
//   o_flag     [N_CH]         sticky event flag
//   o_any      1              OR of all flags, aligned with o_flag
//   o_count    [N_CH*CNT_W]   saturating event counter, channel c at [c*CNT_W +: CNT_W]
module multi_edge_detector #(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       i_data_in,
    input  logic [2*N_CH-1:0]     i_mode,
    input  logic [N_CH-1:0]       i_clr,
    output logic [N_CH-1:0]       o_level,
    output logic [N_CH-1:0]       o_pulse,
    output logic [N_CH-1:0]       o_flag,
    output logic                  o_any,
    output logic [N_CH*CNT_W-1:0] o_count
);

    localparam int unsigned      FW       = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0]    FiltLast = FW'(FILT_LEN - 1);
    localparam logic [FW-1:0]    FiltOne  = FW'(1);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  sync_d [SYNC_STAGES];
    logic [FW-1:0]    filt_q [N_CH];
    logic [FW-1:0]    filt_d [N_CH];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];

    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] level_dly_q, level_dly_d;
    logic [N_CH-1:0] pulse_q, pulse_d;
    logic [N_CH-1:0] flag_q, flag_d;
    logic            any_q, any_d;

    logic [N_CH-1:0] sync_out;
    logic [N_CH-1:0] rise, fall, event_w;

    assign sync_out    = sync_q[SYNC_STAGES-1];
    assign level_dly_d = level_q;
    // Edges are taken on the filtered level, so each accepted level change yields one edge.
    assign rise        = level_q & ~level_dly_q;
    assign fall        = ~level_q & level_dly_q;

    always_comb begin
        sync_d[0] = i_data_in;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Stability filter: a differing level must persist FILT_LEN cycles before it is accepted.
    always_comb begin
        level_d = level_q;
        for (int unsigned c = 0; c < N_CH; c++) begin
            filt_d[c] = filt_q[c];
            if (sync_out[c] == level_q[c]) begin
                filt_d[c] = '0;
            end else if (filt_q[c] == FiltLast) begin
                level_d[c] = sync_out[c];
                filt_d[c]  = '0;
            end else begin
                filt_d[c] = filt_q[c] + FiltOne;
            end
        end
    end

    // Qualification, flag and counter. An event on the same edge as a clear restarts from 1.
    always_comb begin
        event_w = '0;
        flag_d  = flag_q;
        for (int unsigned c = 0; c < N_CH; c++) begin
            cnt_d[c]   = cnt_q[c];
            event_w[c] = (i_mode[2*c] & rise[c]) | (i_mode[2*c+1] & fall[c]);
            if (event_w[c]) begin
                flag_d[c] = 1'b1;
                if (i_clr[c]) begin
                    cnt_d[c] = CntOne;
                end else if (cnt_q[c] != CntMax) begin
                    cnt_d[c] = cnt_q[c] + CntOne;
                end
            end else if (i_clr[c]) begin
                flag_d[c] = 1'b0;
                cnt_d[c]  = '0;
            end
        end
        pulse_d = event_w;
        any_d   = |flag_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int unsigned c = 0; c < N_CH; c++) begin
                filt_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            level_q     <= '0;
            level_dly_q <= '0;
            pulse_q     <= '0;
            flag_q      <= '0;
            any_q       <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int unsigned c = 0; c < N_CH; c++) begin
                filt_q[c] <= filt_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            pulse_q     <= pulse_d;
            flag_q      <= flag_d;
            any_q       <= any_d;
        end
    end

    assign o_level = level_q;
    assign o_pulse = pulse_q;
    assign o_flag  = flag_q;
    assign o_any   = any_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_count
        assign o_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data;
    logic [15:0] mode;
    logic [7:0]  clr;
    logic [7:0]  o_level;
    logic [7:0]  o_pulse;
    logic [7:0]  o_flag;
    logic        o_any;
    logic [63:0] o_count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] mask;
        int         ch;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    multi_edge_detector #(
        .N_CH       (8),
        .SYNC_STAGES(2),
        .FILT_LEN   (4),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data_in(data),
        .i_mode   (mode),
        .i_clr    (clr),
        .o_level  (o_level),
        .o_pulse  (o_pulse),
        .o_flag   (o_flag),
        .o_any    (o_any),
        .o_count  (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected pulse: 7 cycles after the input changes (2 sync + 4 filter + 1 register).
    task automatic push(input logic [7:0] mask, input int ch, input int cnt);
        exp_t e;
        e.cyc  = cyc + 7;
        e.mask = mask;
        e.ch   = ch;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every nonzero pulse vector must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && o_pulse != 8'h00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse=%0h at cycle %0d, required none",
                         o_pulse, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("pulse_mask", 64'(o_pulse), 64'(mon_e.mask));
                chk("pulse_count", 64'(o_count[mon_e.ch*8 +: 8]), 64'(mon_e.cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        data  = 8'h00;
        mode  = 16'hFFFF;
        clr   = 8'h00;
        tick(3);
        chk("rst_level", 64'(o_level), 64'h0);
        chk("rst_pulse", 64'(o_pulse), 64'h0);
        chk("rst_flag", 64'(o_flag), 64'h0);
        chk("rst_any", 64'(o_any), 64'h0);
        chk("rst_count", o_count, 64'h0);
        rst_n = 1'b1;
        tick(5);

        // Basic rising edge on ch0, mode both.
        data[0] = 1'b1;
        push(8'h01, 0, 1);
        tick(12);
        chk("t1_flag0", 64'(o_flag[0]), 64'h1);
        chk("t1_count0", 64'(o_count[7:0]), 64'h1);
        chk("t1_any", 64'(o_any), 64'h1);
        chk("t1_level0", 64'(o_level[0]), 64'h1);

        // ch1 rising only: 3-cycle glitch rejected, 10-cycle pulse gives one rise event.
        mode[3:2] = 2'b01;
        tick(2);
        data[1] = 1'b1;
        tick(3);
        data[1] = 1'b0;
        tick(12);
        chk("t2_glitch_level1", 64'(o_level[1]), 64'h0);
        chk("t2_glitch_count1", 64'(o_count[15:8]), 64'h0);
        data[1] = 1'b1;
        push(8'h02, 1, 1);
        tick(10);
        data[1] = 1'b0;
        tick(15);
        chk("t2_count1", 64'(o_count[15:8]), 64'h1);
        chk("t2_level1", 64'(o_level[1]), 64'h0);

        // ch2 falling only, ch3 off; toggle both four times starting low.
        mode[5:4] = 2'b10;
        mode[7:6] = 2'b00;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            data[2] = (i % 2 == 0);
            data[3] = (i % 2 == 0);
            if (i % 2 == 1) push(8'h04, 2, (i + 1) / 2);
            tick(20);
        end
        tick(10);
        chk("t3_count2", 64'(o_count[23:16]), 64'h2);
        chk("t3_flag2", 64'(o_flag[2]), 64'h1);
        chk("t3_count3", 64'(o_count[31:24]), 64'h0);
        chk("t3_flag3", 64'(o_flag[3]), 64'h0);

        // ch4 both edges, 260 events: counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            data[4] = ~data[4];
            push(8'h10, 4, (i + 1 > 255) ? 255 : i + 1);
            tick(8);
        end
        tick(10);
        chk("t4_count4", 64'(o_count[39:32]), 64'd255);
        chk("t4_flag4", 64'(o_flag[4]), 64'h1);

        // ch5: clear on the same edge as an event -> flag 1, count restarts at 1.
        data[5] = 1'b1;
        push(8'h20, 5, 1);
        tick(12);
        chk("t5_count5_first", 64'(o_count[47:40]), 64'h1);
        data[5] = 1'b0;
        push(8'h20, 5, 1);
        tick(6);
        clr[5] = 1'b1;
        tick(1);
        clr[5] = 1'b0;
        chk("t5_flag5_collide", 64'(o_flag[5]), 64'h1);
        tick(5);
        chk("t5_count5_collide", 64'(o_count[47:40]), 64'h1);
        clr[5] = 1'b1;
        tick(1);
        clr[5] = 1'b0;
        chk("t5_flag5_cleared", 64'(o_flag[5]), 64'h0);
        chk("t5_count5_cleared", 64'(o_count[47:40]), 64'h0);
        chk("t5_any_others", 64'(o_any), 64'h1);
        clr = 8'hFF;
        tick(1);
        clr = 8'h00;
        chk("t5_flag_all_cleared", 64'(o_flag), 64'h0);
        chk("t5_any_cleared", 64'(o_any), 64'h0);
        chk("t5_count_all_cleared", o_count, 64'h0);

        // Reset mid-filter on ch6 discards everything; rising edges reappear after release.
        data[7] = 1'b1;
        push(8'h80, 7, 1);
        tick(12);
        chk("t6_flag7_pre", 64'(o_flag[7]), 64'h1);
        data[6] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 64'(o_level), 64'h0);
        chk("t6_rst_pulse", 64'(o_pulse), 64'h0);
        chk("t6_rst_flag", 64'(o_flag), 64'h0);
        chk("t6_rst_any", 64'(o_any), 64'h0);
        chk("t6_rst_count", o_count, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(8'hC1, 6, 1);
        tick(12);
        chk("t6_level6", 64'(o_level[6]), 64'h1);
        chk("t6_count6", 64'(o_count[55:48]), 64'h1);
        chk("t6_any", 64'(o_any), 64'h1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        chk("missing_pulses", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
